// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler: update kinds, scheduler states,
// default index width and the kind-to-write-enable decode.
package bp_pkg;

  localparam int BP_IDX_W = 10;

  typedef enum logic [1:0] {
    KIND_CONV = 2'd0,
    KIND_BF   = 2'd1,
    KIND_BOTH = 2'd2,
    KIND_RSVD = 2'd3
  } upd_kind_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Returns {wr_en_conv, wr_en_bf} for an update kind; reserved kinds write nothing.
  function automatic logic [1:0] kind_we(input logic [1:0] kind);
    case (upd_kind_e'(kind))
      KIND_CONV: kind_we = 2'b10;
      KIND_BF:   kind_we = 2'b01;
      KIND_BOTH: kind_we = 2'b11;
      default:   kind_we = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue for bp_update_sched: DEPTH-entry circular FIFO (DEPTH a power of two, so
// pointers wrap naturally) with synchronous clear and an occupancy count.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign full   = (count_r == FULL_CNT);
  assign empty  = (count_r == {(PW+1){1'b0}});
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = push & ~full & ~clr;
  assign pop_s  = pop & ~empty & ~clr;

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: post-reset table clear sweep, then queued training writes
// issued when the read port is free. Optional same-cycle bypass via macro BP_UPD_BYPASS_EN.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int IDX_W   = BP_IDX_W,
  parameter int DEPTH   = 4,
  parameter int INIT_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     rd_busy,
  input  logic                     flush,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [1:0]               upd_kind,
  input  logic [IDX_W-1:0]         upd_index,
  input  logic                     upd_taken,
  output logic                     wr_en_conv,
  output logic                     wr_en_bf,
  output logic [IDX_W-1:0]         wr_index,
  output logic                     wr_taken,
  output logic                     wr_clear,
  output logic                     init_busy,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PL_W = IDX_W + 3;
  localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

  state_e            state_r;
  logic [IDX_W-1:0]  sweep_r;
  logic              run_r;
  logic              accept_s;
  logic              issue_ok_s;
  logic              push_s;
  logic              pop_s;
  logic              byp_s;
  logic              clr_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [PL_W-1:0]   fifo_dout_s;

  // run_r is a registered copy of "state is RUN" that stays low while rst is held.
  assign upd_ready  = run_r & ~fifo_full_s;
  assign init_busy  = (state_r == ST_INIT);
  assign accept_s   = upd_valid & upd_ready;
  assign issue_ok_s = (state_r == ST_RUN) & ~stall & ~rd_busy & ~flush;
  assign pop_s      = issue_ok_s & ~fifo_empty_s;
  assign clr_s      = flush & (state_r != ST_INIT);
`ifdef BP_UPD_BYPASS_EN
  assign byp_s      = accept_s & issue_ok_s & fifo_empty_s & (upd_kind != KIND_RSVD);
`else
  assign byp_s      = 1'b0;
`endif
  assign push_s     = accept_s & ~flush & ~byp_s & (upd_kind != KIND_RSVD);

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (PL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({upd_kind, upd_index, upd_taken}),
    .dout  (fifo_dout_s),
    .count (q_count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Scheduler FSM and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      sweep_r    <= {IDX_W{1'b0}};
      run_r      <= 1'b0;
      wr_en_conv <= 1'b0;
      wr_en_bf   <= 1'b0;
      wr_index   <= {IDX_W{1'b0}};
      wr_taken   <= 1'b0;
      wr_clear   <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          wr_taken <= 1'b0;
          // Leave INIT only once the last clear write has been on the port for its cycle.
          if (wr_clear && (wr_index == IDX_MAX)) begin
            state_r    <= ST_RUN;
            run_r      <= 1'b1;
            wr_en_conv <= 1'b0;
            wr_en_bf   <= 1'b0;
            wr_clear   <= 1'b0;
          end else begin
            run_r      <= 1'b0;
            wr_en_conv <= 1'b1;
            wr_en_bf   <= 1'b1;
            wr_clear   <= 1'b1;
            wr_index   <= sweep_r;
            sweep_r    <= sweep_r + IDX_W'(1);
          end
        end
        ST_RUN, ST_DRAIN: begin
          wr_clear <= 1'b0;
          if ((state_r == ST_RUN) && flush) begin
            state_r <= ST_DRAIN;
            run_r   <= 1'b0;
          end else begin
            state_r <= ST_RUN;
            run_r   <= 1'b1;
          end
          if (pop_s) begin
            {wr_en_conv, wr_en_bf} <= kind_we(fifo_dout_s[PL_W-1 -: 2]);
            wr_index               <= fifo_dout_s[IDX_W:1];
            wr_taken               <= fifo_dout_s[0];
          end else if (byp_s) begin
            {wr_en_conv, wr_en_bf} <= kind_we(upd_kind);
            wr_index               <= upd_index;
            wr_taken               <= upd_taken;
          end else begin
            wr_en_conv <= 1'b0;
            wr_en_bf   <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          run_r      <= 1'b0;
          wr_en_conv <= 1'b0;
          wr_en_bf   <= 1'b0;
          wr_clear   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched at default parameters (IDX_W=10, DEPTH=4, INIT_EN=1);
// honours BP_UPD_BYPASS_EN for the single-update latency step.
module tb_bp_update_sched;
  import bp_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, rd_busy, flush, upd_valid, upd_taken;
  logic [1:0] upd_kind;
  logic [9:0] upd_index;
  logic       upd_ready, wr_en_conv, wr_en_bf, wr_taken, wr_clear, init_busy;
  logic [9:0] wr_index;
  logic [2:0] q_count;

  int checks = 0;
  int errors = 0;
  int n;

  bp_update_sched dut (
    .clk(clk), .rst(rst), .stall(stall), .rd_busy(rd_busy), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_kind(upd_kind),
    .upd_index(upd_index), .upd_taken(upd_taken), .wr_en_conv(wr_en_conv),
    .wr_en_bf(wr_en_bf), .wr_index(wr_index), .wr_taken(wr_taken),
    .wr_clear(wr_clear), .init_busy(init_busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; rd_busy = 1'b0; flush = 1'b0;
    upd_valid = 1'b0; upd_kind = 2'd0; upd_index = 10'd0; upd_taken = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_state", 64'({wr_en_conv, wr_en_bf, wr_clear, wr_taken, wr_index, q_count, upd_ready, init_busy}),
        64'({4'b0000, 10'd0, 3'd0, 1'b0, 1'b1}));
    tick(); tick();
    rst = 1'b0;

    // Clear sweep after reset
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (!wr_clear) break;
      chk("sweep_idx", 64'(wr_index), 64'(n));
      chk("sweep_ctl", 64'({wr_en_conv, wr_en_bf, init_busy, upd_ready}), 64'(4'b1110));
      n++;
    end
    chk("sweep_len", 64'(n), 64'(1024));
    chk("post_init", 64'({init_busy, upd_ready, wr_clear, wr_en_conv, wr_en_bf}), 64'(5'b01000));

    // Single kind-0 update
    upd_valid = 1'b1; upd_kind = KIND_CONV; upd_index = 10'h155; upd_taken = 1'b1;
    tick();
    upd_valid = 1'b0;
`ifdef BP_UPD_BYPASS_EN
    chk("single_byp_wr", 64'({wr_en_conv, wr_en_bf, wr_index, wr_taken}), 64'({2'b10, 10'h155, 1'b1}));
    chk("single_byp_cnt", 64'(q_count), 64'(3'd0));
    tick();
    chk("single_byp_done", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));
`else
    chk("single_lat1", 64'({wr_en_conv, wr_en_bf, q_count}), 64'({2'b00, 3'd1}));
    tick();
    chk("single_wr", 64'({wr_en_conv, wr_en_bf, wr_index, wr_taken}), 64'({2'b10, 10'h155, 1'b1}));
    chk("single_cnt", 64'(q_count), 64'(3'd0));
    tick();
    chk("single_done", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));
`endif

    // Five back-to-back pushes while the read port is busy
    rd_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1; upd_kind = KIND_CONV; upd_index = 10'(16 + i); upd_taken = i[0];
      chk("fill_ready", 64'(upd_ready), 64'(i < 4));
      tick();
    end
    upd_valid = 1'b0;
    chk("fill_full", 64'({q_count, upd_ready, wr_en_conv}), 64'({3'd4, 1'b0, 1'b0}));
    rd_busy = 1'b0;
    chk("full_pop_ready", 64'(upd_ready), 64'(1'b0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_wr", 64'({wr_en_conv, wr_en_bf, wr_index, wr_taken}), 64'({2'b10, 10'(16 + i), i[0]}));
      chk("drain_cnt", 64'(q_count), 64'(3 - i));
    end
    tick();
    chk("drain_done", 64'({wr_en_conv, q_count}), 64'({1'b0, 3'd0}));

    // Simultaneous push and pop
    rd_busy = 1'b1;
    upd_valid = 1'b1; upd_kind = KIND_BF; upd_index = 10'h030; upd_taken = 1'b1;
    tick();
    rd_busy = 1'b0; upd_index = 10'h031; upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    chk("pushpop_wr", 64'({wr_en_conv, wr_en_bf, wr_index, wr_taken, q_count}), 64'({2'b01, 10'h030, 1'b1, 3'd1}));
    tick();
    chk("pushpop_wr2", 64'({wr_en_conv, wr_en_bf, wr_index, wr_taken, q_count}), 64'({2'b01, 10'h031, 1'b0, 3'd0}));

    // Flush with three queued updates and a dropped update in the flush cycle
    rd_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_kind = KIND_BOTH; upd_index = 10'(64 + i);
      tick();
    end
    upd_valid = 1'b0;
    chk("flush_pre", 64'(q_count), 64'(3'd3));
    flush = 1'b1; upd_valid = 1'b1; upd_kind = KIND_CONV; upd_index = 10'h3FF;
    tick();
    flush = 1'b0; upd_valid = 1'b0;
    chk("flush_drain", 64'({q_count, upd_ready, wr_en_conv, wr_en_bf}), 64'({3'd0, 3'b000}));
    tick();
    chk("flush_run", 64'({q_count, upd_ready}), 64'({3'd0, 1'b1}));
    rd_busy = 1'b0;
    tick();
    chk("flush_nowr1", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));
    tick();
    chk("flush_nowr2", 64'({wr_en_conv, wr_en_bf, q_count}), 64'({2'b00, 3'd0}));

    // Kind 2 held by stall, then reserved kind
    stall = 1'b1;
    upd_valid = 1'b1; upd_kind = KIND_BOTH; upd_index = 10'h2AA; upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    chk("stall_1", 64'({wr_en_conv, wr_en_bf, q_count}), 64'({2'b00, 3'd1}));
    tick();
    chk("stall_2", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));
    tick();
    chk("stall_3", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));
    stall = 1'b0;
    tick();
    chk("stall_rel", 64'({wr_en_conv, wr_en_bf, wr_index, wr_taken}), 64'({2'b11, 10'h2AA, 1'b0}));
    tick();
    chk("stall_done", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));
    upd_valid = 1'b1; upd_kind = KIND_RSVD; upd_index = 10'h123;
    chk("rsvd_ready", 64'(upd_ready), 64'(1'b1));
    tick();
    upd_valid = 1'b0;
    chk("rsvd_1", 64'({wr_en_conv, wr_en_bf, q_count}), 64'({2'b00, 3'd0}));
    tick();
    chk("rsvd_2", 64'({wr_en_conv, wr_en_bf}), 64'(2'b00));

    // Reset mid-sweep; flush during the sweep must not disturb it
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      chk("sweep2_idx", 64'(wr_index), 64'(c));
      flush = (c == 3);
      upd_valid = (c == 3);
      if (wr_index == 10'd500) break;
    end
    flush = 1'b0; upd_valid = 1'b0;
    chk("sweep2_at500", 64'(wr_index), 64'(10'd500));
    #2 rst = 1'b1;
    #1;
    chk("midsweep_rst", 64'({wr_en_conv, wr_en_bf, wr_clear, wr_taken, wr_index, q_count, upd_ready, init_busy}),
        64'({4'b0000, 10'd0, 3'd0, 1'b0, 1'b1}));
    tick();
    rst = 1'b0;
    tick();
    chk("restart_idx0", 64'({wr_clear, wr_en_conv, wr_en_bf, wr_index}), 64'({3'b111, 10'd0}));
    n = 1;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (!wr_clear) break;
      chk("sweep3_idx", 64'(wr_index), 64'(n));
      n++;
    end
    chk("sweep3_len", 64'(n), 64'(1024));
    chk("sweep3_ready", 64'({init_busy, upd_ready}), 64'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
